// File: rtl/consmax_pkg.sv
// Shared types and sizing for the consmax LUT loader and its stream gate.
package consmax_pkg;

  localparam int IDATA_BIT = 8;
  localparam int CDATA_BIT = 8;
  localparam int EXP_BIT   = 8;
  localparam int MAT_BIT   = 7;
  localparam int LUT_DATA  = EXP_BIT + MAT_BIT + 1;
  localparam int LUT_ADDR  = IDATA_BIT >> 1;
  localparam int LUT_DEPTH = 2 ** LUT_ADDR;
  localparam int NUM_ENTRY = 2 * LUT_DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_READY
  } lut_ld_state_t;

  typedef struct packed {
    logic               sign;
    logic [EXP_BIT-1:0] exp;
    logic [MAT_BIT-1:0] mant;
  } lut_entry_t;

endpackage

// File: rtl/consmax_stream_gate.sv
// Registered valid/ready pass-through; accepts a beat only while en is high.
module consmax_stream_gate #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid
);

  // Ready mirrors the enable so upstream only advances on a beat we register.
  assign in_ready = en;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (en && in_valid) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/consmax_lut_loader.sv
// Sequences host LUT entries into the consmax write port and gates the
// activation stream until a complete table and its shift value are in place.
module consmax_lut_loader
  import consmax_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CDATA_BIT-1:0]  cfg_shift_in,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [LUT_DATA-1:0]   s_data,
  output logic [LUT_ADDR:0]     lut_waddr,
  output logic                  lut_wen,
  output logic [LUT_DATA-1:0]   lut_wdata,
  output logic [CDATA_BIT-1:0]  cfg_consmax_shift,
  input  logic [IDATA_BIT-1:0]  in_idata,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [IDATA_BIT-1:0]  idata,
  output logic                  idata_valid,
  output logic                  busy,
  output logic                  done
);

  localparam logic [LUT_ADDR:0] LAST_CNT = (LUT_ADDR + 1)'(NUM_ENTRY - 1);

  lut_ld_state_t        state_q, state_d;
  logic [LUT_ADDR:0]    cnt_q;
  logic [CDATA_BIT-1:0] shift_q;
  lut_entry_t           wdata_q;

  logic accept;
  logic load_go;
  logic gate_en;

  assign s_ready   = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_DONE);
  assign accept    = s_ready && s_valid;
  assign load_go   = start && ((state_q == ST_IDLE) || (state_q == ST_READY));
  // Closing the gate on the reload edge keeps a beat from slipping past start.
  assign gate_en   = (state_q == ST_READY) && !start;
  assign lut_wdata = wdata_q;

  // NOTE: next-state is defaulted before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  if (accept && (cnt_q == LAST_CNT)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_READY;
      ST_READY: if (start) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      shift_q           <= '0;
      lut_wen           <= 1'b0;
      lut_waddr         <= '0;
      wdata_q           <= '0;
      cfg_consmax_shift <= '0;
      done              <= 1'b0;
    end else begin
      state_q <= state_d;
      lut_wen <= accept;
      // done trails the DONE state so it never overlaps the final write.
      done    <= (state_q == ST_DONE);

      if (load_go) begin
        cnt_q   <= '0;
        shift_q <= cfg_shift_in;
      end else if (accept && (cnt_q != LAST_CNT)) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (accept) begin
        lut_waddr <= cnt_q;
        wdata_q   <= lut_entry_t'(s_data);
      end

      if (state_q == ST_DONE) cfg_consmax_shift <= shift_q;
    end
  end

  consmax_stream_gate #(
    .W(IDATA_BIT)
  ) u_gate (
    .clk      (clk),
    .rst      (rst),
    .en       (gate_en),
    .in_data  (in_idata),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (idata),
    .out_valid(idata_valid)
  );

endmodule
